// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register responder: FSM states, command
// byte layout and synchroniser depth default.
package spi_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StRdata,
        StWdata,
        StIgnore
    } spi_state_e;

    // Command byte layout: R/W flag, auto-increment flag, address in the low bits.
    localparam int unsigned RW_BIT = 7;
    localparam int unsigned MB_BIT = 6;

    localparam int unsigned SYNC_STAGES_DEFAULT = 2;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous SPI pin, with single-clk
// rise and fall pulses derived from the synchronised value.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter int unsigned STAGES    = SYNC_STAGES_DEFAULT,
    parameter logic        RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q[0] <= din;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise = sync_q[STAGES-1] & ~prev_q;
    assign fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_reg_responder.sv
// SPI mode-3 slave that turns command/data frames into register read and
// write strobes, with optional address auto-increment for bursts.
module spi_reg_responder
    import spi_pkg::*;
#(
    parameter int unsigned ADDR_W      = 6,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_sclk,
    input  logic              spi_ss_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic [ADDR_W-1:0] reg_addr,
    output logic              reg_rd,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              reg_wr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              busy,
    output logic              frame_err
);

    localparam int unsigned CNT_W    = $clog2(DATA_W);
    localparam int unsigned SETTLE_W = $clog2(SYNC_STAGES + 2);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic sclk_rise, sclk_fall, ss_rise, ss_fall;

    spi_sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sync_sclk (
        .clk   (clk),
        .reset (reset),
        .din   (spi_sclk),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sync_ss (
        .clk   (clk),
        .reset (reset),
        .din   (spi_ss_n),
        .rise  (ss_rise),
        .fall  (ss_fall)
    );

    // MOSI shares the SCLK delay so the rise pulse lines up with its bit.
    logic [SYNC_STAGES-1:0] mosi_q;
    logic                   mosi_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            mosi_q <= '0;
        end else begin
            mosi_q[0] <= spi_mosi;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                mosi_q[i] <= mosi_q[i-1];
            end
        end
    end

    assign mosi_s = mosi_q[SYNC_STAGES-1];

    spi_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-2:0]   rx_q, rx_d;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic                miso_q, miso_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                mb_q, mb_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                reg_rd_q, reg_rd_d;
    logic                reg_wr_q, reg_wr_d;
    logic                frame_err_q, frame_err_d;
    logic                tx_load_q;
    logic [SETTLE_W-1:0] settle_q, settle_d;

    logic              active;
    logic [DATA_W-1:0] rx_shift;
    logic              byte_done;

    assign active    = state_q inside {StCmd, StRdata, StWdata};
    assign rx_shift  = {rx_q, mosi_s};
    assign byte_done = sclk_rise && (cnt_q == LAST_BIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            miso_q      <= 1'b0;
            addr_q      <= '0;
            mb_q        <= 1'b0;
            wdata_q     <= '0;
            reg_rd_q    <= 1'b0;
            reg_wr_q    <= 1'b0;
            frame_err_q <= 1'b0;
            tx_load_q   <= 1'b0;
            settle_q    <= SETTLE_W'(SYNC_STAGES + 1);
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            miso_q      <= miso_d;
            addr_q      <= addr_d;
            mb_q        <= mb_d;
            wdata_q     <= wdata_d;
            reg_rd_q    <= reg_rd_d;
            reg_wr_q    <= reg_wr_d;
            frame_err_q <= frame_err_d;
            tx_load_q   <= reg_rd_q;
            settle_q    <= settle_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        miso_d      = miso_q;
        addr_d      = addr_q;
        mb_d        = mb_q;
        wdata_d     = wdata_q;
        reg_rd_d    = 1'b0;
        reg_wr_d    = 1'b0;
        frame_err_d = 1'b0;
        settle_d    = (settle_q != '0) ? settle_q - 1'b1 : settle_q;

        // Post-increment after the write strobe so reg_addr is stable while it is high.
        if (reg_wr_q) begin
            addr_d = addr_q + ADDR_W'(mb_q);
        end

        if (active && sclk_rise) begin
            rx_d  = rx_shift[DATA_W-2:0];
            cnt_d = byte_done ? '0 : cnt_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                cnt_d  = '0;
                miso_d = 1'b0;
                // A fall while the synchroniser is still settling means SS_n was low at reset.
                if (ss_fall && (settle_q != '0)) begin
                    state_d = StIgnore;
                end else if (ss_fall && !ss_rise) begin
                    state_d = StCmd;
                end
            end
            StCmd: begin
                if (byte_done) begin
                    addr_d = rx_shift[ADDR_W-1:0];
                    mb_d   = rx_shift[MB_BIT];
                    if (rx_shift[RW_BIT]) begin
                        reg_rd_d = 1'b1;
                    end else begin
                        state_d = StWdata;
                    end
                end
                if (tx_load_q) begin
                    tx_d    = reg_rdata;
                    state_d = StRdata;
                end
            end
            StRdata: begin
                if (sclk_fall) begin
                    miso_d = tx_q[DATA_W-1];
                    tx_d   = tx_q << 1;
                end
                if (byte_done) begin
                    addr_d   = addr_q + ADDR_W'(mb_q);
                    reg_rd_d = 1'b1;
                end
                if (tx_load_q) begin
                    tx_d = reg_rdata;
                end
            end
            StWdata: begin
                if (byte_done) begin
                    reg_wr_d = 1'b1;
                    wdata_d  = rx_shift;
                end
            end
            StIgnore: ;
            default: state_d = StIdle;
        endcase

        if (ss_rise && (state_q != StIdle)) begin
            state_d     = StIdle;
            cnt_d       = '0;
            reg_rd_d    = 1'b0;
            reg_wr_d    = 1'b0;
            frame_err_d = (cnt_q != '0) || (state_q == StCmd);
        end
    end

    assign spi_miso_oe = (state_q == StRdata);
    assign spi_miso    = spi_miso_oe & miso_q;
    assign reg_addr    = addr_q;
    assign reg_rd      = reg_rd_q;
    assign reg_wr      = reg_wr_q;
    assign reg_wdata   = wdata_q;
    assign busy        = active;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_spi_reg_responder.sv
// Directed bench for spi_reg_responder: table of whole frames plus
// hand-written abort and reset-during-frame sequences.
module tb_spi_reg_responder;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned HALF   = 6;

    logic              clk;
    logic              reset;
    logic              spi_sclk;
    logic              spi_ss_n;
    logic              spi_mosi;
    logic              spi_miso;
    logic              spi_miso_oe;
    logic [ADDR_W-1:0] reg_addr;
    logic              reg_rd;
    logic [DATA_W-1:0] reg_rdata;
    logic              reg_wr;
    logic [DATA_W-1:0] reg_wdata;
    logic              busy;
    logic              frame_err;

    spi_reg_responder #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .spi_sclk    (spi_sclk),
        .spi_ss_n    (spi_ss_n),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .reg_addr    (reg_addr),
        .reg_rd      (reg_rd),
        .reg_rdata   (reg_rdata),
        .reg_wr      (reg_wr),
        .reg_wdata   (reg_wdata),
        .busy        (busy),
        .frame_err   (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "timeout");
    end

    // Register model: unwritten address n reads back n.
    logic              model_clr;
    logic [7:0]        mem [64];
    logic [63:0]       written;

    always @(posedge clk) begin
        if (model_clr) begin
            written <= '0;
        end else begin
            if (reg_rd) reg_rdata <= written[reg_addr] ? mem[reg_addr] : 8'(reg_addr);
            if (reg_wr) begin
                mem[reg_addr]     <= reg_wdata;
                written[reg_addr] <= 1'b1;
            end
        end
    end

    // Strobe monitor, sampled mid-cycle.
    logic [13:0] wr_q [$];
    logic [5:0]  rd_q [$];
    int unsigned err_pulses, err_cycles, wide_cnt;
    logic        wr_prev, rd_prev, err_prev;

    initial begin
        wr_prev = 1'b0; rd_prev = 1'b0; err_prev = 1'b0; wide_cnt = 0;
    end

    always @(negedge clk) begin
        if (reg_wr) wr_q.push_back({reg_addr, reg_wdata});
        if (reg_rd) rd_q.push_back(reg_addr);
        if (frame_err) err_cycles++;
        if (frame_err && !err_prev) err_pulses++;
        if ((reg_wr && wr_prev) || (reg_rd && rd_prev)) wide_cnt++;
        wr_prev  = reg_wr;
        rd_prev  = reg_rd;
        err_prev = frame_err;
    end

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic wait_clks(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon();
        wr_q.delete();
        rd_q.delete();
        err_pulses = 0;
        err_cycles = 0;
    endtask

    task automatic spi_bits(input logic [7:0] d, input int unsigned nbits, output logic [7:0] r);
        r = '0;
        for (int i = 0; i < int'(nbits); i++) begin
            spi_sclk = 1'b0;
            spi_mosi = d[7-i];
            wait_clks(HALF);
            r[7-i]   = spi_miso;
            spi_sclk = 1'b1;
            wait_clks(HALF);
        end
    endtask

    task automatic run_frame(input logic [3:0][7:0] mo, input int unsigned nb,
                             output logic [3:0][7:0] rx, output logic busy_mid);
        logic [7:0] rb;
        rx       = '0;
        busy_mid = 1'b0;
        spi_ss_n = 1'b0;
        wait_clks(HALF);
        for (int b = 0; b < int'(nb); b++) begin
            spi_bits(mo[b], 8, rb);
            rx[b] = rb;
            if (b == 0) busy_mid = busy;
        end
        wait_clks(HALF);
        spi_ss_n = 1'b1;
        wait_clks(12);
    endtask

    typedef struct {
        string            name;
        int unsigned      nbytes;
        logic [3:0][7:0]  mosi;
        logic [3:0]       rx_mask;
        logic [3:0][7:0]  exp_rx;
        int unsigned      n_wr;
        logic [1:0][13:0] exp_wr;
        int unsigned      n_rd;
        logic [5:0]       rd_first;
        logic [5:0]       rd_last;
    } vec_t;

    function automatic vec_t mk(string nm, int unsigned nb, logic [31:0] mo, logic [3:0] mask,
                                logic [31:0] erx, int unsigned nwr, logic [27:0] ewr,
                                int unsigned nrd, logic [5:0] rf, logic [5:0] rl);
        vec_t v;
        v.name = nm; v.nbytes = nb; v.mosi = mo; v.rx_mask = mask; v.exp_rx = erx;
        v.n_wr = nwr; v.exp_wr = ewr; v.n_rd = nrd; v.rd_first = rf; v.rd_last = rl;
        return v;
    endfunction

    vec_t            vecs [4];
    logic [3:0][7:0] rx;
    logic [7:0]      rb;
    logic            bmid;

    initial begin
        reset     = 1'b1;
        model_clr = 1'b1;
        spi_sclk  = 1'b1;
        spi_ss_n  = 1'b1;
        spi_mosi  = 1'b0;
        clear_mon();
        wait_clks(4);

        check("rst.reg_addr",  32'(reg_addr),    32'h0);
        check("rst.reg_rd",    32'(reg_rd),      32'h0);
        check("rst.reg_wr",    32'(reg_wr),      32'h0);
        check("rst.reg_wdata", 32'(reg_wdata),   32'h0);
        check("rst.miso",      32'(spi_miso),    32'h0);
        check("rst.miso_oe",   32'(spi_miso_oe), 32'h0);
        check("rst.busy",      32'(busy),        32'h0);
        check("rst.frame_err", 32'(frame_err),   32'h0);

        reset     = 1'b0;
        model_clr = 1'b0;
        wait_clks(8);
        check("idle.busy", 32'(busy), 32'h0);

        vecs[0] = mk("single_wr", 2, 32'h0000_082D, 4'b0000, 32'h0,
                     1, {14'h0, 6'h2D, 8'h08}, 0, 6'h0, 6'h0);
        vecs[1] = mk("wrap_wr", 3, 32'h00BB_AA7F, 4'b0000, 32'h0,
                     2, {6'h00, 8'hBB, 6'h3F, 8'hAA}, 0, 6'h0, 6'h0);
        vecs[2] = mk("burst_rd", 4, 32'h0000_00F2, 4'b1110, 32'h3433_3200,
                     0, 28'h0, 4, 6'h32, 6'h35);
        vecs[3] = mk("single_rd", 3, 32'h0000_0085, 4'b0110, 32'h0005_0500,
                     0, 28'h0, 3, 6'h05, 6'h05);

        for (int v = 0; v < 4; v++) begin
            clear_mon();
            run_frame(vecs[v].mosi, vecs[v].nbytes, rx, bmid);
            check({vecs[v].name, ".busy_mid"}, 32'(bmid), 32'h1);
            check({vecs[v].name, ".busy_end"}, 32'(busy), 32'h0);
            check({vecs[v].name, ".oe_end"}, 32'(spi_miso_oe), 32'h0);
            check({vecs[v].name, ".frame_err"}, err_pulses, 32'h0);
            check({vecs[v].name, ".n_wr"}, 32'(wr_q.size()), vecs[v].n_wr);
            for (int k = 0; k < int'(vecs[v].n_wr); k++) begin
                check({vecs[v].name, ".wr"}, (k < wr_q.size()) ? 32'(wr_q[k]) : 32'hFFFF_FFFF,
                      32'(vecs[v].exp_wr[k]));
            end
            check({vecs[v].name, ".n_rd"}, 32'(rd_q.size()), vecs[v].n_rd);
            if (vecs[v].n_rd > 0) begin
                check({vecs[v].name, ".rd_first"},
                      (rd_q.size() > 0) ? 32'(rd_q[0]) : 32'hFFFF_FFFF, 32'(vecs[v].rd_first));
                check({vecs[v].name, ".rd_last"},
                      (rd_q.size() > 0) ? 32'(rd_q[rd_q.size()-1]) : 32'hFFFF_FFFF,
                      32'(vecs[v].rd_last));
            end
            for (int b = 0; b < 4; b++) begin
                if (vecs[v].rx_mask[b]) begin
                    check({vecs[v].name, ".miso_byte"}, 32'(rx[b]), 32'(vecs[v].exp_rx[b]));
                end
            end
        end

        // Write frame aborted five bits into the data byte.
        clear_mon();
        spi_ss_n = 1'b0;
        wait_clks(HALF);
        spi_bits(8'h10, 8, rb);
        check("abort.busy_mid", 32'(busy), 32'h1);
        spi_bits(8'hFF, 5, rb);
        wait_clks(HALF);
        spi_ss_n = 1'b1;
        wait_clks(12);
        check("abort.n_wr", 32'(wr_q.size()), 32'h0);
        check("abort.err_pulses", err_pulses, 32'h1);
        check("abort.err_cycles", err_cycles, 32'h1);
        check("abort.busy_end", 32'(busy), 32'h0);

        // Select pulse with no clocks: aborted while still in the command byte.
        clear_mon();
        spi_ss_n = 1'b0;
        wait_clks(12);
        spi_ss_n = 1'b1;
        wait_clks(12);
        check("cmd_abort.err_pulses", err_pulses, 32'h1);

        // Reset in the middle of a read frame, SS_n kept low across it.
        clear_mon();
        spi_ss_n = 1'b0;
        wait_clks(HALF);
        spi_bits(8'hC3, 8, rb);
        spi_bits(8'h00, 3, rb);
        check("rstmid.oe_before", 32'(spi_miso_oe), 32'h1);
        reset = 1'b1;
        wait_clks(1);
        check("rstmid.oe_in_reset", 32'(spi_miso_oe), 32'h0);
        check("rstmid.miso_in_reset", 32'(spi_miso), 32'h0);
        wait_clks(2);
        reset = 1'b0;
        clear_mon();
        spi_bits(8'hFF, 8, rb);
        wait_clks(6);
        check("ignore.busy", 32'(busy), 32'h0);
        check("ignore.oe", 32'(spi_miso_oe), 32'h0);
        check("ignore.n_rd", 32'(rd_q.size()), 32'h0);
        check("ignore.n_wr", 32'(wr_q.size()), 32'h0);
        spi_ss_n = 1'b1;
        wait_clks(12);
        check("ignore.err_pulses", err_pulses, 32'h0);

        clear_mon();
        run_frame(32'h0000_0080, 2, rx, bmid);
        check("after_rst.busy_mid", 32'(bmid), 32'h1);
        check("after_rst.n_rd", 32'(rd_q.size()), 32'h2);
        check("after_rst.rd_addr", (rd_q.size() > 0) ? 32'(rd_q[0]) : 32'hFFFF_FFFF, 32'h0);
        check("after_rst.miso_byte", 32'(rx[1]), 32'hBB);
        check("after_rst.frame_err", err_pulses, 32'h0);

        check("strobe_width", wide_cnt, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_reg_responder.md
SPI_REG_RESPONDER -- requirements
Module: spi_reg_responder

Interface
REQ-001 SHALL have parameters: ADDR_W, 6, register address width; DATA_W, 8, register and frame byte width; SYNC_STAGES, 2, SPI input synchroniser depth.
REQ-002 SHALL have ports: clk  in  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: spi_sclk  in  1  SPI clock from the master, mode 3 (CPOL=1, CPHA=1), at most clk/10.
REQ-005 SHALL have ports: spi_ss_n  in  1  active-low slave select.
REQ-006 SHALL have ports: spi_mosi  in  1  master-to-slave data, MSB first.
REQ-007 SHALL have ports: spi_miso  out  1  slave-to-master data, MSB first.
REQ-008 SHALL have ports: spi_miso_oe  out  1  MISO output enable; the top level uses it for tristate.
REQ-009 SHALL have ports: reg_addr  out  ADDR_W  register address.
REQ-010 SHALL have ports: reg_rd  out  1  read strobe, one clk wide.
REQ-011 SHALL have ports: reg_rdata  in  DATA_W  read data, valid the clk after reg_rd.
REQ-012 SHALL have ports: reg_wr  out  1  write strobe, one clk wide.
REQ-013 SHALL have ports: reg_wdata  out  DATA_W  write data.
REQ-014 SHALL have ports: busy  out  1  high while a frame is active.
REQ-015 SHALL have ports: frame_err  out  1  one-clk pulse when a frame is aborted.

Function
REQ-016 SHALL pass spi_sclk, spi_ss_n and spi_mosi through SYNC_STAGES flops, then detect SCLK rise and fall and SS_n fall and rise from the synchronised values.
REQ-017 SHALL use FSM states IDLE, CMD, RDATA, WDATA, and IGNORE.
REQ-018 SHALL move IDLE->CMD on SS_n fall, clearing the bit counter and setting busy.
REQ-019 SHALL shift MOSI into the RX shift register on each SCLK rise; the bit counter counts 0..7 and wraps to 0.
REQ-020 SHALL latch the command on the 8th rise in CMD: bit7 = R/W (1 = read), bit6 = MB (auto-increment), bits5:0 = address.
REQ-021 For a read command, SHALL pulse reg_rd with reg_addr equal to the command address on the clk after the command latches.
REQ-022 For a read, SHALL load reg_rdata into the TX shift register one clk after reg_rd, then enter RDATA.
REQ-023 For a write command, SHALL enter WDATA.
REQ-024 In RDATA, SHALL drive spi_miso from TX[7] and shift TX on each SCLK fall; the first fall after the command presents the data MSB.
REQ-025 At the end of each RDATA byte (8th rise), SHALL prefetch: address +1 if MB=1, else the same address; pulse reg_rd; reload TX before the next fall.
REQ-026 At the end of each WDATA byte (8th rise), SHALL pulse reg_wr for one clk with reg_wdata = RX byte and reg_addr = current address; the address then advances +1 if MB=1.
REQ-027 SHALL wrap address increments from 2^ADDR_W-1 to 0.
REQ-028 SHALL hold spi_miso_oe high only in RDATA; spi_miso SHALL be 0 whenever spi_miso_oe is low.
REQ-029 SHALL handle SS_n rise in any non-IDLE state: return to IDLE and clear busy; partial bytes are discarded and never written.
REQ-030 On that SS_n rise, SHALL pulse frame_err if the bit counter is non-zero or the state is CMD.
REQ-031 If SS_n fall and rise are detected in the same clk, SHALL treat them as a rise (stay IDLE, no error).
REQ-032 If SS_n is already low when reset releases, SHALL enter IGNORE and wait there for SS_n rise, then go to IDLE.

Reset
REQ-033 While reset is high, SHALL force: state IDLE, counters and shift registers 0, reg_addr 0, reg_rd 0, reg_wr 0, reg_wdata 0, spi_miso 0, spi_miso_oe 0, busy 0, frame_err 0.
REQ-034 SHALL preset synchroniser flops to SCLK=1, SS_n=1, MOSI=0.
REQ-035 A reset mid-frame SHALL issue no strobes and SHALL follow REQ-032.

Structure
REQ-036 SHALL place the FSM state enum, command bit positions (RW_BIT=7, MB_BIT=6) and the SYNC_STAGES default in shared package spi_pkg.
REQ-037 SHALL use one sub-module, spi_sync_edge: synchroniser plus rise/fall pulses; it is instantiated for spi_sclk and spi_ss_n.

Verification
REQ-038 Single write: frame 0x2D, 0x08 (W, MB=0) -> exactly one reg_wr with addr 0x2D, wdata 0x08; frame_err stays 0.
REQ-039 Burst read: frame 0xF2 plus 3 dummy bytes, register model addr n returns n -> MISO bytes 0x32, 0x33, 0x34; reg_rd pulses 4 times.
REQ-040 Wrap: write burst 0x7F, 0xAA, 0xBB -> reg_wr at 0x3F (0xAA), then 0x00 (0xBB).
REQ-041 Abort: SS_n rises after 5 bits of a data byte in a write -> no reg_wr for that byte; frame_err is 1 for one clk; busy goes 0.
REQ-042 Reset mid-read frame -> MISO oe drops immediately; FSM holds in IGNORE until SS_n is high; the next frame 0x80 reads addr 0 correctly.
REQ-043 Non-burst read: 0x85 plus 2 dummy bytes -> both bytes come from addr 0x05.
